// File: rtl/gray_wptr_ctrl.sv
// gray_wptr_ctrl
// Write-side pointer controller for the CDC async FIFO. Owns the binary write
// pointer, publishes it as a registered Gray pointer, synchronizes the read
// side's Gray pointer into this clock and derives full / almost-full / level /
// overflow from it.
//
// DLY is accepted so existing instantiations bind unchanged; registers update
// without any intra-assignment delay.
module gray_wptr_ctrl #(
  parameter int DLY         = 1,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LEVEL = 6
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rd_gray_ptr_i,
  output logic                  wr_ack_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Full when the write Gray pointer equals the synchronized read Gray pointer
  // with its two top bits inverted (one full lap ahead).
  localparam logic [ADDR_WIDTH:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] AFULL_THR = PW'(AFULL_LEVEL);

  // Reject parameter sets outside the supported range at elaboration time.
  if (ADDR_WIDTH < 1 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH || DLY < 0) begin : g_param_err
    $error("gray_wptr_ctrl: illegal parameter set");
  end

  // Binary to Gray: each bit XORed with its upper neighbour.
  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
    return b ^ {1'b0, b[ADDR_WIDTH:1]};
  endfunction

  // Gray to binary by prefix XOR from the MSB down.
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0]                   wbin_r;
  logic [ADDR_WIDTH:0]                   wgray_r;
  logic [SYNC_STAGES-1:0][ADDR_WIDTH:0]  sync_r;
  logic                                  full_r;
  logic                                  afull_r;
  logic [ADDR_WIDTH:0]                   level_r;
  logic                                  ovf_r;

  logic                                  wr_ack_s;
  logic [ADDR_WIDTH:0]                   wbin_next_s;
  logic [ADDR_WIDTH:0]                   wgray_next_s;
  logic [ADDR_WIDTH:0]                   rg_sync_s;
  logic [ADDR_WIDTH:0]                   rbin_sync_s;
  logic [ADDR_WIDTH:0]                   level_next_s;
  logic                                  full_next_s;
  logic                                  afull_next_s;

  // Next pointer, Gray image and flag/level values for the coming edge.
  always_comb begin
    wr_ack_s     = wr_en_i & ~full_r;
    wbin_next_s  = wbin_r + {{ADDR_WIDTH{1'b0}}, wr_ack_s};
    wgray_next_s = bin2gray(wbin_next_s);
    rg_sync_s    = sync_r[SYNC_STAGES-1];
    rbin_sync_s  = gray2bin(rg_sync_s);
    full_next_s  = (wgray_next_s == (rg_sync_s ^ FULL_MASK));
    level_next_s = wbin_next_s - rbin_sync_s;
    afull_next_s = (level_next_s >= AFULL_THR);
  end

  // Plain flop chain bringing the read Gray pointer into this clock domain.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_r <= '0;
    end else begin
      sync_r[0] <= rd_gray_ptr_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Write pointer state and registered status outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wbin_r  <= '0;
      wgray_r <= '0;
      full_r  <= 1'b0;
      afull_r <= 1'b0;
      level_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      wbin_r  <= wbin_next_s;
      wgray_r <= wgray_next_s;
      full_r  <= full_next_s;
      afull_r <= afull_next_s;
      level_r <= level_next_s;
      ovf_r   <= wr_en_i & full_r;
    end
  end

  assign wr_ack_o      = wr_ack_s;
  assign wr_addr_o     = wbin_r[ADDR_WIDTH-1:0];
  assign wr_gray_ptr_o = wgray_r;
  assign full_o        = full_r;
  assign almost_full_o = afull_r;
  assign level_o       = level_r;
  assign overflow_o    = ovf_r;

endmodule
